// File: rtl/brg_cgra_link_concentrator.sv
// Merges num_links_p request links into one accelerator port by round-robin arbitration and
// routes responses back to their source link, tracking outstanding requests per link.
module brg_cgra_link_concentrator #(
  parameter int unsigned width_p           = 32,
  parameter int unsigned ret_width_p       = 32,
  parameter int unsigned num_links_p       = 4,
  parameter int unsigned lg_fifo_depth_p   = 2,
  parameter int unsigned max_out_credits_p = 16,
  localparam int unsigned id_width_lp      = (num_links_p > 1) ? $clog2(num_links_p) : 1,
  localparam int unsigned cnt_width_lp     = $clog2(max_out_credits_p + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic [num_links_p-1:0]                   link_en_i,
  input  logic [num_links_p-1:0]                   link_v_i,
  input  logic [num_links_p-1:0][width_p-1:0]      link_data_i,
  output logic [num_links_p-1:0]                   link_ready_and_o,
  output logic                                     xcel_v_o,
  output logic [width_p-1:0]                       xcel_data_o,
  output logic [id_width_lp-1:0]                   xcel_link_id_o,
  input  logic                                     xcel_yumi_i,
  input  logic                                     xcel_ret_v_i,
  input  logic [ret_width_p-1:0]                   xcel_ret_data_i,
  input  logic [id_width_lp-1:0]                   xcel_ret_link_id_i,
  output logic                                     xcel_ret_ready_and_o,
  output logic [num_links_p-1:0]                   link_ret_v_o,
  output logic [ret_width_p-1:0]                   link_ret_data_o,
  input  logic [num_links_p-1:0]                   link_ret_ready_and_i,
  output logic [num_links_p-1:0][cnt_width_lp-1:0] out_credits_o,
  output logic                                     idle_o,
  output logic                                     error_o
);
  localparam int unsigned depth_lp     = 1 << lg_fifo_depth_p;
  localparam int unsigned ptr_width_lp = (lg_fifo_depth_p > 0) ? lg_fifo_depth_p : 1;

  typedef logic [id_width_lp-1:0]   id_t;
  typedef logic [cnt_width_lp-1:0]  cnt_t;
  typedef logic [ptr_width_lp-1:0]  ptr_t;
  typedef logic [lg_fifo_depth_p:0] fill_t;

  logic [width_p-1:0] mem_q [num_links_p][depth_lp];
  ptr_t  rd_ptr_q [num_links_p];
  ptr_t  rd_ptr_d [num_links_p];
  ptr_t  wr_ptr_q [num_links_p];
  ptr_t  wr_ptr_d [num_links_p];
  fill_t fill_q   [num_links_p];
  fill_t fill_d   [num_links_p];
  cnt_t  credits_q[num_links_p];
  cnt_t  credits_d[num_links_p];
  id_t   rr_q, rr_d;
  logic  error_q, error_d;

  logic [num_links_p-1:0] full, empty, enq, deq, elig, ret_hit, ret_dec;
  logic        any_elig, ret_id_ok, ret_sel_ready, ret_hs;
  id_t         winner;
  int unsigned idx;

  // Ready looks only at registered fill, so a full FIFO refuses even while draining.
  always_comb begin
    for (int i = 0; i < num_links_p; i++) begin
      full[i]             = (fill_q[i] == fill_t'(depth_lp));
      empty[i]            = (fill_q[i] == '0);
      link_ready_and_o[i] = link_en_i[i] & ~full[i] & ~reset_i;
      enq[i]              = link_v_i[i] & link_ready_and_o[i];
      elig[i]             = ~empty[i] & link_en_i[i]
                            & (credits_q[i] < cnt_t'(max_out_credits_p));
    end
  end

  // First eligible link at or above rr_q, wrapping.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < num_links_p; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= num_links_p) idx = idx - num_links_p;
      if (!any_elig && elig[id_t'(idx)]) begin
        any_elig = 1'b1;
        winner   = id_t'(idx);
      end
    end
  end

  assign xcel_v_o       = any_elig & ~reset_i;
  assign xcel_link_id_o = winner;
  assign xcel_data_o    = mem_q[winner][rd_ptr_q[winner]];

  always_comb begin
    ret_id_ok     = 1'b0;
    ret_sel_ready = 1'b0;
    for (int i = 0; i < num_links_p; i++) begin
      link_ret_v_o[i] = xcel_ret_v_i & ~reset_i & (xcel_ret_link_id_i == id_t'(i));
      if (xcel_ret_link_id_i == id_t'(i)) begin
        ret_id_ok     = 1'b1;
        ret_sel_ready = link_ret_ready_and_i[i];
      end
    end
  end

  // Out-of-range ids are accepted and dropped so the accelerator cannot wedge.
  assign xcel_ret_ready_and_o = ~reset_i & (~ret_id_ok | ret_sel_ready);
  assign ret_hs               = xcel_ret_v_i & xcel_ret_ready_and_o;
  assign link_ret_data_o      = xcel_ret_data_i;

  always_comb begin
    error_d = error_q | (ret_hs & ~ret_id_ok);
    rr_d    = rr_q;
    if (xcel_yumi_i && xcel_v_o) begin
      rr_d = (winner == id_t'(num_links_p - 1)) ? '0 : winner + 1'b1;
    end
    for (int i = 0; i < num_links_p; i++) begin
      deq[i]     = xcel_yumi_i & xcel_v_o & (winner == id_t'(i));
      ret_hit[i] = ret_hs & (xcel_ret_link_id_i == id_t'(i));
      ret_dec[i] = ret_hit[i] & (credits_q[i] != '0);
      error_d    = error_d | (ret_hit[i] & (credits_q[i] == '0));
      case ({deq[i], ret_dec[i]})
        2'b10:   credits_d[i] = credits_q[i] + 1'b1;
        2'b01:   credits_d[i] = credits_q[i] - 1'b1;
        default: credits_d[i] = credits_q[i];
      endcase
      fill_d[i]   = fill_q[i] + fill_t'(enq[i]) - fill_t'(deq[i]);
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      if (deq[i]) rd_ptr_d[i] = (rd_ptr_q[i] == ptr_t'(depth_lp - 1)) ? '0 : rd_ptr_q[i] + 1'b1;
      if (enq[i]) wr_ptr_d[i] = (wr_ptr_q[i] == ptr_t'(depth_lp - 1)) ? '0 : wr_ptr_q[i] + 1'b1;
    end
  end

  always_comb begin
    idle_o = 1'b1;
    for (int i = 0; i < num_links_p; i++) begin
      idle_o           = idle_o & empty[i] & (credits_q[i] == '0);
      out_credits_o[i] = credits_q[i];
    end
  end

  assign error_o = error_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_links_p; i++) begin
        rd_ptr_q[i]  <= '0;
        wr_ptr_q[i]  <= '0;
        fill_q[i]    <= '0;
        credits_q[i] <= '0;
      end
      rr_q    <= '0;
      error_q <= 1'b0;
    end else begin
      for (int i = 0; i < num_links_p; i++) begin
        rd_ptr_q[i]  <= rd_ptr_d[i];
        wr_ptr_q[i]  <= wr_ptr_d[i];
        fill_q[i]    <= fill_d[i];
        credits_q[i] <= credits_d[i];
      end
      rr_q    <= rr_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_links_p; i++) begin
      if (enq[i]) mem_q[i][wr_ptr_q[i]] <= link_data_i[i];
    end
  end

endmodule

// File: tb/tb_brg_cgra_link_concentrator.sv
// Bench for brg_cgra_link_concentrator: directed scenarios plus random traffic, checked by a
// negedge monitor against per-link expected-data queues and a queue/integer reference model.
module tb_brg_cgra_link_concentrator;
  localparam int N    = 4;
  localparam int W    = 16;
  localparam int RW   = 12;
  localparam int LGD  = 2;
  localparam int D    = 1 << LGD;
  localparam int MAXC = 3;
  localparam int IDW  = $clog2(N);
  localparam int CW   = $clog2(MAXC + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           link_en, link_v, link_ready, link_ret_v, link_ret_ready;
  logic [N-1:0][W-1:0]    link_data;
  logic                   xcel_v, yumi, ret_v, ret_ready, idle, error;
  logic [W-1:0]           xcel_data;
  logic [IDW-1:0]         xcel_id, ret_id;
  logic [RW-1:0]          ret_data, link_ret_data;
  logic [N-1:0][CW-1:0]   out_credits;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] mq [N][$];
  int           mcred [N];
  int           mrr;
  bit           merr;

  brg_cgra_link_concentrator #(
    .width_p          (W),
    .ret_width_p      (RW),
    .num_links_p      (N),
    .lg_fifo_depth_p  (LGD),
    .max_out_credits_p(MAXC)
  ) dut (
    .clk_i               (clk),
    .reset_i             (rst),
    .link_en_i           (link_en),
    .link_v_i            (link_v),
    .link_data_i         (link_data),
    .link_ready_and_o    (link_ready),
    .xcel_v_o            (xcel_v),
    .xcel_data_o         (xcel_data),
    .xcel_link_id_o      (xcel_id),
    .xcel_yumi_i         (yumi),
    .xcel_ret_v_i        (ret_v),
    .xcel_ret_data_i     (ret_data),
    .xcel_ret_link_id_i  (ret_id),
    .xcel_ret_ready_and_o(ret_ready),
    .link_ret_v_o        (link_ret_v),
    .link_ret_data_o     (link_ret_data),
    .link_ret_ready_and_i(link_ret_ready),
    .out_credits_o       (out_credits),
    .idle_o              (idle),
    .error_o             (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then apply this cycle's handshakes to the model.
  int           w, c0;
  bit           any, mbusy;
  logic [N-1:0] exp_ready, exp_ret_v;
  logic         exp_ret_ready;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_link_ready", link_ready, 0);
      check("rst_xcel_v", xcel_v, 0);
      check("rst_ret_ready", ret_ready, 0);
      check("rst_link_ret_v", link_ret_v, 0);
      check("rst_idle", idle, 1);
      check("rst_error", error, 0);
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        mcred[i] = 0;
      end
      mrr  = 0;
      merr = 0;
    end else begin
      any = 0;
      w   = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (mrr + k) % N;
        if (!any && mq[idx].size() > 0 && link_en[idx] && mcred[idx] < MAXC) begin
          any = 1;
          w   = idx;
        end
      end
      check("xcel_v", xcel_v, any);
      if (any) begin
        check("xcel_link_id", xcel_id, w);
        check("xcel_data", xcel_data, mq[w][0]);
      end
      mbusy = 0;
      for (int i = 0; i < N; i++) begin
        exp_ready[i] = link_en[i] && (mq[i].size() < D);
        check("out_credits", out_credits[i], mcred[i]);
        if (mq[i].size() > 0 || mcred[i] != 0) mbusy = 1;
      end
      check("link_ready", link_ready, exp_ready);
      check("error", error, merr);
      check("idle", idle, !mbusy);
      exp_ret_ready = link_ret_ready[ret_id];
      exp_ret_v     = ret_v ? (N'(1) << ret_id) : '0;
      check("ret_ready", ret_ready, exp_ret_ready);
      check("link_ret_v", link_ret_v, exp_ret_v);
      check("link_ret_data", link_ret_data, ret_data);
      c0 = mcred[ret_id];
      for (int i = 0; i < N; i++) if (link_v[i] && exp_ready[i]) mq[i].push_back(link_data[i]);
      if (any && yumi) begin
        void'(mq[w].pop_front());
        mcred[w]++;
        mrr = (w + 1) % N;
      end
      if (ret_v && exp_ret_ready) begin
        if (c0 == 0) merr = 1;
        else mcred[ret_id]--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; link_v = '0; link_en = '0; yumi = 0; ret_v = 0; ret_id = '0;
    link_ret_ready = '0;
    step();
    step();
    rst = 0;
  endtask

  logic [W-1:0] sl_vals [3];
  logic [W-1:0] full_vals [4];
  int           j;

  initial begin
    rst = 1; link_en = '0; link_v = '0; link_data = '0; yumi = 0;
    ret_v = 0; ret_id = '0; ret_data = '0; link_ret_ready = '0;
    #1;
    check("init_idle", idle, 1);
    check("init_xcel_v", xcel_v, 0);
    do_reset();

    // Single link: three requests on link 2, yumi held high.
    sl_vals[0] = 16'hA; sl_vals[1] = 16'hB; sl_vals[2] = 16'hC;
    link_en = 4'b0100; yumi = 1;
    for (int k = 0; k < 3; k++) begin
      link_v[2] = 1; link_data[2] = sl_vals[k];
      step();
      #2;
      check("single_v", xcel_v, 1);
      check("single_data", xcel_data, sl_vals[k]);
      check("single_id", xcel_id, 2);
    end
    link_v = '0;
    step(); step();
    check("single_credits", out_credits[2], 3);
    check("single_v_done", xcel_v, 0);

    // Fairness: two entries in every FIFO, grants must rotate 0,1,2,3,0,1,2,3.
    do_reset();
    link_en = '1;
    for (int k = 0; k < 2; k++) begin
      link_v = '1;
      for (int i = 0; i < N; i++) link_data[i] = W'($urandom);
      step();
    end
    link_v = '0; yumi = 1;
    for (int g = 0; g < 8; g++) begin
      #2;
      check("fair_v", xcel_v, 1);
      check("fair_order", xcel_id, g % N);
      step();
    end

    // Credit stall on link 1, then a return releases the held request.
    do_reset();
    link_en = 4'b0010; yumi = 1; link_ret_ready = '1;
    for (int k = 0; k < 4; k++) begin
      link_v[1] = 1; link_data[1] = W'($urandom);
      step();
    end
    link_v = '0;
    step(); step(); step();
    #2;
    check("stall_v", xcel_v, 0);
    check("stall_credits", out_credits[1], MAXC);
    check("stall_idle", idle, 0);
    ret_v = 1; ret_id = 1;
    step();
    ret_v = 0;
    #2;
    check("release_v", xcel_v, 1);
    check("release_id", xcel_id, 1);
    step();
    // Dequeue and return to link 1 in the same cycle.
    ret_v = 1; ret_id = 1; link_v[1] = 1; link_data[1] = W'($urandom);
    step();
    link_v = '0;
    #2;
    check("simul_v", xcel_v, 1);
    step();
    ret_v = 0;
    #2;
    check("simul_credits", out_credits[1], 2);
    // Return to link 3 which has nothing outstanding.
    ret_v = 1; ret_id = 3;
    step();
    ret_v = 0;
    #2;
    check("err_set", error, 1);
    check("err_credits", out_credits[3], 0);
    step(); step();
    check("err_sticky", error, 1);

    // FIFO full on link 0, disable, then re-enable and drain in order.
    do_reset();
    link_en = '1;
    for (int k = 0; k < D; k++) begin
      link_v[0] = 1; link_data[0] = W'($urandom); full_vals[k] = link_data[0];
      step();
    end
    link_data[0] = 16'hDEAD;
    #2;
    check("full_ready", link_ready[0], 0);
    step();
    link_v = '0; link_en[0] = 0; yumi = 1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("disabled_v", xcel_v, 0);
      step();
    end
    link_en[0] = 1; ret_id = 0; link_ret_ready = '1;
    for (int k = 0; k < D; k++) begin
      ret_v = (out_credits[0] != 0);
      #2;
      check("drain_v", xcel_v, 1);
      check("drain_data", xcel_data, full_vals[k]);
      step();
    end
    ret_v = 0;

    // Reset mid-operation with two buffered entries and two outstanding.
    do_reset();
    link_en = 4'b0001;
    for (int k = 0; k < D; k++) begin
      link_v[0] = 1; link_data[0] = W'($urandom);
      step();
    end
    link_v = '0; yumi = 1;
    step(); step();
    yumi = 0;
    #2;
    check("pre_rst_credits", out_credits[0], 2);
    rst = 1; ret_v = 1; ret_id = 0; link_v[0] = 1;
    #1;
    check("mid_rst_ready", link_ready, 0);
    check("mid_rst_v", xcel_v, 0);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_credits", out_credits[0], 0);
    check("mid_rst_ret_ready", ret_ready, 0);
    check("mid_rst_ret_v", link_ret_v, 0);
    step(); step();
    rst = 0; ret_v = 0; link_v = '0; yumi = 1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("post_rst_v", xcel_v, 0);
      step();
    end

    // Random traffic against the model.
    do_reset();
    link_en = '1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) link_en = ($urandom_range(0, 1) == 0) ? N'($urandom) : '1;
      link_v = N'($urandom);
      for (int i = 0; i < N; i++) link_data[i] = W'($urandom);
      link_ret_ready = N'($urandom);
      ret_data = RW'($urandom);
      ret_v = 0;
      if ($urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, N - 1);
        if (out_credits[j] != 0) begin
          ret_v  = 1;
          ret_id = IDW'(j);
        end
      end
      #1;
      yumi = ($urandom_range(0, 1) == 1) && xcel_v;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/brg_cgra_link_concentrator.md
# brg_cgra_link_concentrator

Parametrised N-link concentrator for CGRA accelerator pods. It merges `num_links_p` manycore request links into one accelerator request port and routes accelerator responses back to the originating link. Each link has its own input FIFO, an enable bit and an outstanding-request credit counter, and links are served by round-robin arbitration. It sits between the pod's per-link SDR endpoints and the accelerator core, replacing the fixed 4-link point-to-point wiring.

## Interface
Parameters:
- `width_p`, `"inv"`: request packet width in bits.
- `ret_width_p`, `"inv"`: response packet width in bits.
- `num_links_p`, 4: number of links; must be at least 1.
- `lg_fifo_depth_p`, 2: log2 of the per-link input FIFO depth.
- `max_out_credits_p`, 16: maximum outstanding requests per link; must be at least 1.
- `id_width_lp` (localparam): `BSG_SAFE_CLOG2(num_links_p)`.
- `cnt_width_lp` (localparam): `BSG_SAFE_CLOG2(max_out_credits_p+1)`.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `link_en_i`  in  num_links_p  per-link enable.
- `link_v_i`  in  num_links_p  request valid, per link.
- `link_data_i`  in  num_links_p x width_p  request data.
- `link_ready_and_o`  out  num_links_p  request ready.
- `xcel_v_o`  out  1  merged request valid.
- `xcel_data_o`  out  width_p  merged request data.
- `xcel_link_id_o`  out  id_width_lp  source link of the current request.
- `xcel_yumi_i`  in  1  accelerator consumes the request.
- `xcel_ret_v_i`  in  1  response valid.
- `xcel_ret_data_i`  in  ret_width_p  response data.
- `xcel_ret_link_id_i`  in  id_width_lp  destination link of the response.
- `xcel_ret_ready_and_o`  out  1  response ready.
- `link_ret_v_o`  out  num_links_p  response valid, per link.
- `link_ret_data_o`  out  ret_width_p  response data, broadcast to all links.
- `link_ret_ready_and_i`  in  num_links_p  per-link response ready.
- `out_credits_o`  out  num_links_p x cnt_width_lp  outstanding count per link.
- `idle_o`  out  1  all FIFOs empty and all counters zero.
- `error_o`  out  1  sticky protocol error.

## Operation
- **Per-link FIFO** (depth 2^lg_fifo_depth_p).
  - `link_ready_and_o[i]` = `link_en_i[i]` & !full[i] & !reset_i.
  - Enqueue on `link_v_i[i]` & `link_ready_and_o[i]`.
  - ready depends only on registered state; a full FIFO never enqueues, even when it dequeues in the same cycle.
- **Eligibility.** Link i is eligible when its FIFO is non-empty, `link_en_i[i]`=1 and `out_credits_o[i]` < `max_out_credits_p`.
- **Arbitration.**
  - Round-robin pointer rr. The winner is the first eligible link at or above rr, wrapping.
  - `xcel_v_o` = any eligible. `xcel_data_o` and `xcel_link_id_o` come from the winner's FIFO head.
  - `xcel_yumi_i` is legal only while `xcel_v_o`=1. When it is asserted: dequeue the winner, increment its counter, set rr = winner+1 (wrap at num_links_p).
  - rr is unchanged when no yumi occurs.
- **Disabling a link.** Clearing `link_en_i` stops both enqueue and arbitration for that link. FIFO contents and the counter are retained, and service resumes when the link is re-enabled.
- **Response path.**
  - `link_ret_v_o[j]` = `xcel_ret_v_i` & (`xcel_ret_link_id_i`==j).
  - `xcel_ret_ready_and_o` = `link_ret_ready_and_i[xcel_ret_link_id_i]`.
  - A response handshake decrements the counter of the addressed link.
- **Counter rules.**
  - A dequeue and a return to the same link in the same cycle leave the counter unchanged.
  - A return to a link whose count is 0 leaves the counter at 0 and sets `error_o`.
  - `xcel_ret_link_id_i` >= num_links_p sets `error_o`; the response is still handshaken (ready=1) and dropped.
- **error_o** stays set until reset.

## Timing
- **Reset values** (asynchronous): all FIFOs empty, counters 0, rr=0, `error_o`=0. While `reset_i`=1: `link_ready_and_o`=0, `xcel_v_o`=0, `xcel_ret_ready_and_o`=0, `link_ret_v_o`=0, `idle_o`=1.
- **Reset mid-operation:** buffered requests are discarded and the counters are cleared.
- **Request latency:** enqueue in cycle t makes the data visible on `xcel_data_o` at cycle t+1 at the earliest.
- **Sustained throughput:** one request per cycle.
- **Response path** is purely combinational, with zero latency.
- `out_credits_o` and `error_o` update on the clock edge after the causing handshake.
- `idle_o` is combinational from registered state.

## Test plan
- **Single link:** after reset, enable only link 2 and send 3 requests (0xA, 0xB, 0xC) with yumi held at 1. Required: the same data in order, `xcel_link_id_o`=2, first output at cycle t+1, `out_credits_o[2]`=3.
- **Fairness:** all 4 links enabled, each FIFO holding 2 entries, yumi always 1. Required: grant order 0,1,2,3,0,1,2,3.
- **Credit stall:** `max_out_credits_p`=2, send 3 requests on link 1 with no returns. Required: the third request is held with `xcel_v_o`=0. After one return to link 1, the third request issues the next cycle.
- **Simultaneous events and errors:**
  - Dequeue and return to the same link in one cycle: counter unchanged.
  - Return to link 3 with count 0: `error_o`=1, counter stays 0.
- **FIFO full and disable:** lg depth 2, fill link 0 with 4 entries while yumi=0. Required: `link_ready_and_o[0]`=0. Then disable link 0 and set yumi=1: no grants from link 0. Re-enable: all 4 entries drain in order.
- **Reset mid-operation:** assert `reset_i` with 2 entries buffered and count 2. Required: all outputs take their reset values immediately, `idle_o`=1, and no stale data appears after reset is released.
